// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 access types,
// FSM state codes and the per-access context latched when a request is issued.
package mem_access_unit_pkg;

  // funct3 access types
  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  // FSM states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Context needed to extract load data once the bus answers.
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] off;
  } acc_lat_t;

  // True for the funct3 codes this unit can execute at all.
  function automatic logic mop_defined(input logic [2:0] op);
    return (op == MOP_B) || (op == MOP_H) || (op == MOP_W) ||
           (op == MOP_BU) || (op == MOP_HU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purely combinational lane logic: store byte enables and replication, load
// byte/halfword extraction with extension, and the illegal/misaligned check.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  acc_lat_t    ld_ctx,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        bad
);

  logic        illegal;
  logic        misaligned;
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (mem_op[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (mem_op)
      MOP_H, MOP_HU: misaligned = addr_lo[0];
      MOP_W:         misaligned = |addr_lo;
      default:       misaligned = 1'b0;
    endcase
  end

  // Unsigned variants have no store form.
  assign illegal = (mem_r & mem_w) | ~mop_defined(mem_op) | (mem_w & mem_op[2]);
  assign bad     = (mem_r | mem_w) & (illegal | misaligned);

  assign rd_shift = rdata >> {ld_ctx.off, 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = ld_ctx.off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    rdata_ext = rdata;
    case (ld_ctx.op)
      MOP_B:   rdata_ext = {{24{rd_byte[7]}}, rd_byte};
      MOP_BU:  rdata_ext = {24'b0, rd_byte};
      MOP_H:   rdata_ext = {{16{rd_half[15]}}, rd_half};
      MOP_HU:  rdata_ext = {16'b0, rd_half};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one word-wide bus request per access,
// stalls the core while it is in flight, and reports faults and timeouts.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  mem_op,
  input  logic        mem_w,
  input  logic        mem_r,
  output logic [31:0] data_from_ram,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  acc_lat_t         lat;

  logic [3:0]  be_c;
  logic [31:0] wrep_c;
  logic [31:0] rext_c;
  logic        bad_c;
  logic        access;
  logic        go;
  logic        timeout_hit;

  mem_lane_align u_align (
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_op    (mem_op),
    .addr_lo   (addr[1:0]),
    .wdata     (wdata),
    .ld_ctx    (lat),
    .rdata     (bus_rdata),
    .be        (be_c),
    .wdata_rep (wrep_c),
    .rdata_ext (rext_c),
    .bad       (bad_c)
  );

  assign access      = mem_r | mem_w;
  assign go          = access & ~bad_c;
  assign timeout_hit = (state == REQ) & ~bus_ack & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign bus_req = (state == REQ);
  // Gated by rst so the core sees no stall or fault while reset is held.
  assign stall   = ~rst & (((state == IDLE) & go) | (state == REQ));
  assign fault   = ~rst & (((state == IDLE) & access & bad_c) | timeout_hit);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: every register, including the bus-facing outputs, is cleared by
  // reset so nothing stale is presented to the bus or the core afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      lat           <= '0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_be        <= '0;
      bus_wdata     <= '0;
      data_from_ram <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state     <= REQ;
            cnt       <= '0;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_we    <= mem_w;
            bus_be    <= be_c;
            bus_wdata <= wrep_c;
            lat       <= '{op: mem_op, off: addr[1:0]};
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we) data_from_ram <= rext_c;
            cnt   <= '0;
            state <= DONE;
          end else if (timeout_hit) begin
            // An aborted load returns zero rather than stale data.
            if (!bus_we) data_from_ram <= '0;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: a transaction-level model predicts every output on every
// cycle; directed accesses pin the model with hand-computed values.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic [2:0]  mem_op = '0;
  logic        mem_w = 1'b0, mem_r = 1'b0, bus_ack = 1'b0;
  logic [31:0] data_from_ram, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        stall, fault, bus_req, bus_we;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_op(mem_op),
    .mem_w(mem_w), .mem_r(mem_r), .data_from_ram(data_from_ram),
    .stall(stall), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle and the model's held bus/result state.
  logic        e_stall = 0, e_fault = 0, e_req = 0;
  logic        m_we = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_data = '0;
  logic [3:0]  m_be = '0;
  logic        check_en = 0;
  int stall_cyc = 0, fault_cyc = 0, req_cyc = 0;

  always @(negedge clk) begin
    if (check_en) begin
      check("stall",         32'(stall),   32'(e_stall));
      check("fault",         32'(fault),   32'(e_fault));
      check("bus_req",       32'(bus_req), 32'(e_req));
      check("bus_we",        32'(bus_we),  32'(m_we));
      check("bus_addr",      bus_addr,     m_addr);
      check("bus_be",        32'(bus_be),  32'(m_be));
      check("bus_wdata",     bus_wdata,    m_wdata);
      check("data_from_ram", data_from_ram, m_data);
      if (stall)   stall_cyc++;
      if (fault)   fault_cyc++;
      if (bus_req) req_cyc++;
    end
  end

  function automatic logic [3:0] m_be_f(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000, 3'b100: return 4'(1 << a);
      3'b001, 3'b101: return (a >= 2) ? 4'hC : 4'h3;
      default:        return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_rep(input logic [2:0] op, input logic [31:0] w);
    case (op[1:0])
      2'b00:   return 32'(w & 32'hFF) * 32'h0101_0101;
      2'b01:   return 32'(w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] op, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] sh, v;
    sh = rd >> (8 * int'(a));
    case (op)
      3'b000: begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFF_FF00; end
      3'b100:       v = sh & 32'hFF;
      3'b001: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF_0000; end
      3'b101:       v = sh & 32'hFFFF;
      default:      v = rd;
    endcase
    return v;
  endfunction

  function automatic logic m_ok(input logic r, input logic w, input logic [2:0] op, input logic [1:0] a);
    logic legal, aligned;
    legal   = (op == 0 || op == 1 || op == 2 || op == 4 || op == 5) && !(r && w) && !(w && op >= 4);
    aligned = (op == 1 || op == 5) ? (a % 2 == 0) : (op == 2) ? (a == 0) : 1'b1;
    return legal && aligned;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    mem_r = 0; mem_w = 0;
    e_stall = 0; e_fault = 0; e_req = 0;
  endtask

  // One access from the IDLE cycle through DONE; delay >= T means no ack.
  task automatic do_access(input logic r, input logic w, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int delay);
    mem_r = r; mem_w = w; mem_op = op; addr = a; wdata = wd;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    e_req = 0;
    if (!(r || w) || !m_ok(r, w, op, a[1:0])) begin
      e_stall = 0; e_fault = r || w;
      step();
      go_idle();
      return;
    end
    e_stall = 1; e_fault = 0;
    step();
    m_addr = {a[31:2], 2'b00}; m_we = w; m_be = m_be_f(op, a[1:0]); m_wdata = m_rep(op, wd);
    for (int k = 0; k < T; k++) begin
      bus_ack   = (k == delay);
      bus_rdata = bus_ack ? rd : $urandom;
      e_req = 1; e_stall = 1; e_fault = !bus_ack && (k == T - 1);
      step();
      if (bus_ack) begin
        if (r) m_data = m_ext(op, a[1:0], rd);
        break;
      end
      if (k == T - 1 && r) m_data = '0;
    end
    // DONE: anything on the inputs or the ack line must be ignored.
    e_req = 0; e_stall = 0; e_fault = 0;
    mem_r = 1'($urandom_range(0, 1)); mem_w = 1'($urandom_range(0, 1));
    mem_op = 3'($urandom_range(0, 7)); addr = $urandom;
    bus_ack = 1'($urandom_range(0, 1));
    step();
    go_idle();
  endtask

  initial begin
    int s0, f0, q0;
    logic r, w;
    logic [2:0] op;
    logic [31:0] a;

    // Reset state
    #2;
    check("rst_stall", 32'(stall), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_req", 32'(bus_req), 0);
    check("rst_we", 32'(bus_we), 0);
    check("rst_be", 32'(bus_be), 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_data", data_from_ram, 0);
    step();
    rst = 0;
    check_en = 1;
    step();

    // LW, ack in first REQ cycle: two stall cycles
    s0 = stall_cyc;
    do_access(1, 0, MOP_W, 32'h100, 0, 32'hDEAD_BEEF, 0);
    check("lw_data", data_from_ram, 32'hDEAD_BEEF);
    check("lw_addr", bus_addr, 32'h100);
    check("lw_be", 32'(bus_be), 32'hF);
    check("lw_stall_cycles", stall_cyc - s0, 2);

    // LB / LBU from the top byte lane
    do_access(1, 0, MOP_B, 32'h103, 0, 32'h8011_2233, 0);
    check("lb_be", 32'(bus_be), 32'b1000);
    check("lb_data", data_from_ram, 32'hFFFF_FF80);
    do_access(1, 0, MOP_BU, 32'h103, 0, 32'h8011_2233, 1);
    check("lbu_data", data_from_ram, 32'h0000_0080);

    // Asynchronous reset while a request is outstanding
    mem_r = 1; mem_w = 0; mem_op = MOP_W; addr = 32'h40; bus_ack = 0;
    e_stall = 1; e_fault = 0; e_req = 0;
    step();
    m_addr = 32'h40; m_we = 0; m_be = 4'hF; m_wdata = wdata;
    check_en = 0;
    #1 rst = 1;
    #1;
    check("midrst_req", 32'(bus_req), 0);
    check("midrst_stall", 32'(stall), 0);
    check("midrst_fault", 32'(fault), 0);
    check("midrst_data", data_from_ram, 0);
    go_idle();
    step();
    rst = 0;
    m_addr = '0; m_we = 0; m_be = '0; m_wdata = '0; m_data = '0;
    check_en = 1;
    step();
    do_access(1, 0, MOP_W, 32'h44, 0, 32'h1234_5678, 2);
    check("postrst_data", data_from_ram, 32'h1234_5678);

    // SH with ack after 3 wait cycles: five stall cycles, stable bus
    s0 = stall_cyc;
    do_access(0, 1, MOP_H, 32'h202, 32'h0000_ABCD, 0, 3);
    check("sh_we", 32'(bus_we), 1);
    check("sh_be", 32'(bus_be), 32'b1100);
    check("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    check("sh_stall_cycles", stall_cyc - s0, 5);

    // Misaligned and illegal accesses
    s0 = stall_cyc; f0 = fault_cyc; q0 = req_cyc;
    do_access(1, 0, MOP_W, 32'h101, 0, 0, 0);
    check("mis_fault_cycles", fault_cyc - f0, 1);
    check("mis_req_cycles", req_cyc - q0, 0);
    check("mis_stall_cycles", stall_cyc - s0, 0);
    check("mis_data_kept", data_from_ram, 32'h1234_5678);
    f0 = fault_cyc;
    do_access(1, 1, MOP_W, 32'h100, 0, 0, 0);
    check("rw_fault_cycles", fault_cyc - f0, 1);
    step();

    // Load timeout
    s0 = stall_cyc; f0 = fault_cyc; q0 = req_cyc;
    do_access(1, 0, MOP_W, 32'h300, 0, 0, 99);
    check("to_req_cycles", req_cyc - q0, T);
    check("to_fault_cycles", fault_cyc - f0, 1);
    check("to_stall_cycles", stall_cyc - s0, T + 1);
    check("to_data", data_from_ram, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        r = 1'($urandom_range(0, 1)); w = !r;
        case ($urandom_range(0, 4))
          0: op = MOP_B;  1: op = MOP_H;  2: op = MOP_W;
          3: op = MOP_BU; default: op = MOP_HU;
        endcase
        if (w && op[2]) op[2] = 1'b0;
        if (op[1:0] == 2'b01) a[0] = 1'b0;
        if (op == MOP_W) a[1:0] = 2'b00;
      end
      do_access(r, w, op, a, $urandom, $urandom, int'($urandom_range(0, T + 1)));
      if ($urandom_range(0, 3) == 0) begin
        bus_ack = 1'($urandom_range(0, 1));
        step();
      end
    end

    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
